// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the node-memory arbiter: FSM state encoding,
// default widths and the byte-address map of the node memory.
package mem_arb_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } arb_state_t;

   localparam int N_REQ_DEF    = 3;
   localparam int ADDR_W_DEF   = 11;
   localparam int DATA_W_DEF   = 16;
   localparam int LOCK_MAX_DEF = 16;

   localparam logic [ADDR_W_DEF-1:0] MM_FLAGS       = 11'h000;
   localparam logic [ADDR_W_DEF-1:0] MM_KNOWN_SINKS = 11'h008;
   localparam logic [ADDR_W_DEF-1:0] MM_WORST_HOPS  = 11'h028;
   localparam logic [ADDR_W_DEF-1:0] MM_NEIGHBOR_ID = 11'h048;
   localparam logic [ADDR_W_DEF-1:0] MM_CLUSTER_ID  = 11'h0C8;
   localparam logic [ADDR_W_DEF-1:0] MM_BATTERY     = 11'h148;
   localparam logic [ADDR_W_DEF-1:0] MM_QVALUE      = 11'h1C8;
   localparam logic [ADDR_W_DEF-1:0] MM_SINK_IDS    = 11'h248;
   localparam logic [ADDR_W_DEF-1:0] MM_HCM         = 11'h648;
   localparam logic [ADDR_W_DEF-1:0] MM_BETTER_NB   = 11'h668;
   localparam logic [ADDR_W_DEF-1:0] MM_COUNT0      = 11'h688;
   localparam logic [ADDR_W_DEF-1:0] MM_COUNT1      = 11'h68A;
   localparam logic [ADDR_W_DEF-1:0] MM_COUNT2      = 11'h68C;
   localparam logic [ADDR_W_DEF-1:0] MM_COUNT3      = 11'h68E;

   // Index width that stays at least one bit wide for degenerate sizes.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Rotating-priority selector: first set, non-excluded request at or above ptr,
// wrapping around. Purely combinational.
module rr_pick #(
   parameter int N  = 3,
   parameter int PW = 2
) (
   input  logic [N-1:0]  req_vec,
   input  logic [PW-1:0] ptr,
   input  logic [N-1:0]  excl,
   output logic [PW-1:0] idx,
   output logic          valid
);

   always_comb begin
      int c;
      c     = 0;
      idx   = '0;
      valid = 1'b0;
      // Walk from the farthest candidate down so the nearest one wins last.
      for (int k = N - 1; k >= 0; k--) begin
         c = int'(ptr) + k;
         if (c >= N) c = c - N;
         if (req_vec[c] && !excl[c]) begin
            idx   = PW'(c);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter for the shared node memory, with bounded owner locking
// for list scans and odd-address protection.
//
// state    | meaning
// ST_IDLE  | no owner; any request is picked at the next edge
// ST_GRANT | owner holds the memory port; gnt follows req[owner]
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int N_REQ    = N_REQ_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int LOCK_MAX = LOCK_MAX_DEF
) (
   input  logic                    clock,
   input  logic                    nrst,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ-1:0]        lock,
   input  logic [N_REQ-1:0]        wr,
   input  logic [N_REQ*ADDR_W-1:0] addr,
   input  logic [N_REQ*DATA_W-1:0] wdata,
   output logic [N_REQ-1:0]        gnt,
   output logic [DATA_W-1:0]       rdata,
   output logic                    err,
   output logic                    busy,
   output logic [ADDR_W-1:0]       mem_address,
   output logic                    mem_wr_en,
   output logic [DATA_W-1:0]       mem_data_in,
   input  logic [DATA_W-1:0]       mem_data_out
);

   localparam int PW = idx_width(N_REQ);
   localparam int CW = idx_width(LOCK_MAX);

   arb_state_t    state;
   logic [PW-1:0] owner;
   logic [PW-1:0] ptr;
   logic [CW-1:0] lock_cnt;

   logic [ADDR_W-1:0] own_addr;
   logic [DATA_W-1:0] own_wdata;
   logic              own_req;
   logic              active;
   logic              hold;
   logic [PW-1:0]     next_ptr;
   logic [PW-1:0]     pick_ptr;
   logic [N_REQ-1:0]  pick_excl;
   logic [PW-1:0]     pick_idx;
   logic              pick_valid;

   assign own_addr  = addr[owner*ADDR_W +: ADDR_W];
   assign own_wdata = wdata[owner*DATA_W +: DATA_W];
   assign own_req   = req[owner];
   assign busy      = (state == ST_GRANT);
   assign hold      = own_req & lock[owner] & (lock_cnt < CW'(LOCK_MAX - 1));
   assign next_ptr  = (owner == PW'(N_REQ - 1)) ? '0 : owner + PW'(1);

   // Nothing is granted or written while reset is held, even mid-lock.
   assign active    = busy & nrst & own_req;

   // One selector serves both the idle pick and the same-edge handover.
   assign pick_ptr  = busy ? next_ptr : ptr;

   always_comb begin
      pick_excl = '0;
      if (busy) pick_excl[owner] = 1'b1;
   end

   rr_pick #(.N(N_REQ), .PW(PW)) u_pick (
      .req_vec (req),
      .ptr     (pick_ptr),
      .excl    (pick_excl),
      .idx     (pick_idx),
      .valid   (pick_valid)
   );

   always_comb begin
      gnt = '0;
      if (active) gnt[owner] = 1'b1;
   end

   assign err         = active & own_addr[0];
   assign mem_wr_en   = active & wr[owner] & ~own_addr[0];
   assign mem_address = busy ? own_addr : '0;
   assign mem_data_in = busy ? own_wdata : '0;
   assign rdata       = mem_data_out;

   always_ff @(posedge clock) begin
      if (!nrst) begin
         state    <= ST_IDLE;
         owner    <= '0;
         ptr      <= '0;
         lock_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pick_valid) begin
                  owner    <= pick_idx;
                  lock_cnt <= '0;
                  state    <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               if (hold) begin
                  lock_cnt <= lock_cnt + CW'(1);
               end else begin
                  ptr      <= next_ptr;
                  lock_cnt <= '0;
                  if (pick_valid) owner <= pick_idx;
                  else            state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter N_REQ, default 3: number of requesters sharing the node memory.
REQ-002 Parameter ADDR_W, default 11: byte address width of the memory.
REQ-003 Parameter DATA_W, default 16: memory word width.
REQ-004 Parameter LOCK_MAX, default 16: maximum consecutive grants to one locked owner.
REQ-005 Port clock, input, 1: single clock; all state changes on its rising edge.
REQ-006 Port nrst, input, 1: reset, synchronous and active-low.
REQ-007 Port req, input, N_REQ: per-requester transaction request, held until granted.
REQ-008 Port lock, input, N_REQ: owner keeps the memory for its next transaction (list scans).
REQ-009 Port wr, input, N_REQ: 1 = write, 0 = read.
REQ-010 Port addr, input, N_REQ*ADDR_W: packed byte addresses; requester i occupies slice i.
REQ-011 Port wdata, input, N_REQ*DATA_W: packed write words.
REQ-012 Port gnt, output, N_REQ: one-hot; the transaction is accepted in the cycle gnt[i]=1.
REQ-013 Port rdata, output, DATA_W: read word; valid in the cycle gnt is high.
REQ-014 Port err, output, 1: one-cycle pulse when a granted access uses an odd address.
REQ-015 Port busy, output, 1: high while the state is GRANT.
REQ-016 Ports mem_address (ADDR_W), mem_wr_en (1) and mem_data_in (DATA_W), outputs; mem_data_out (DATA_W), input: the memory-side port.

Function
REQ-017 The FSM SHALL have states IDLE and GRANT, plus an owner register and a round-robin pointer.
REQ-018 In IDLE with any req set, the block SHALL select an owner at the clock edge, scanning from the pointer upward with wrap, and enter GRANT; grant latency is one cycle.
REQ-019 In GRANT, gnt[owner] SHALL equal req[owner]; all other gnt bits are 0.
REQ-020 In GRANT, mem_address and mem_data_in SHALL carry the owner's slices, and mem_wr_en = req[owner] & wr[owner] & ~addr[owner][0].
REQ-021 rdata SHALL be mem_data_out passed through combinationally; the write commits at the edge ending the gnt cycle.
REQ-022 At the end of a GRANT cycle, if lock[owner] & req[owner] and lock_cnt < LOCK_MAX-1, the block SHALL stay in GRANT with the same owner and increment lock_cnt.
REQ-023 Otherwise the block SHALL set pointer = owner+1 (mod N_REQ) and clear lock_cnt. It SHALL then re-arbitrate in the same edge among req excluding the old owner: if any is set, it stays in GRANT with the new owner (no bubble); if none is set, it goes to IDLE.
REQ-024 When lock_cnt reaches LOCK_MAX-1, release SHALL be forced regardless of lock; if no other requester is waiting, the old owner may be re-granted via IDLE.
REQ-025 If the owner drops req while in GRANT, the block SHALL issue no write and no gnt, and SHALL release per REQ-023.
REQ-026 For a granted odd address, the block SHALL suppress the write, pulse err, and still assert gnt so the requester is not hung.
REQ-027 Outside GRANT, mem_wr_en SHALL be 0, mem_address 0, and mem_data_in 0.

Reset
REQ-028 When nrst=0 at a clock edge, the block SHALL set state IDLE, owner 0, pointer 0, lock_cnt 0, gnt 0, err 0, busy 0 and mem_wr_en 0.
REQ-029 Reset asserted during a locked sequence SHALL abandon it; no write SHALL occur in the reset cycle.

Structure
REQ-030 Package mem_arb_pkg SHALL hold the state enum, the width constants and the memory-map base constants (FLAGS 0x000, KNOWN_SINKS 0x008, WORST_HOPS 0x028, NEIGHBOR_ID 0x048, CLUSTER_ID 0x0C8, BATTERY 0x148, QVALUE 0x1C8, SINK_IDS 0x248, HCM 0x648, BETTER_NB 0x668, counts at 0x688/0x68A/0x68C/0x68E).
REQ-031 Sub-module rr_pick SHALL be a purely combinational rotating-priority selector (inputs: request vector, pointer, exclude mask; outputs: index, valid).

Verification
REQ-032 Single read: req[1]=1, wr=0, addr=0x688 with memory 0x0005 -> gnt[1] high one cycle after req; in that cycle rdata=0x0005 and mem_wr_en=0.
REQ-033 Contention: req=3'b111 from reset -> grant order 0,1,2 on consecutive cycles with no idle cycle; busy stays high for 3 cycles.
REQ-034 Locked scan: requester 2 holds lock and reads 0x048..0x04E while req[0] is also set -> four consecutive gnt[2] pulses, then gnt[0] in the next cycle.
REQ-035 Starvation cap: requester 0 is locked indefinitely and req[1]=1 -> exactly 16 gnt[0] pulses, then gnt[1].
REQ-036 Odd address: write of 0xABCD to 0x009 -> gnt asserted, err pulses once, mem_wr_en=0, and word 0x008 is unchanged.
REQ-037 Mid-lock reset: nrst low during the third locked grant -> the next cycle shows gnt=0, busy=0, and arbitration restarts at requester 0.
